bit_io_scan: RTL
================

BIT_IO_SCAN -- requirements
Module: bit_io_scan

Interface
REQ-001 Parameter AWIDTH, default 8: bit-RAM address width.
REQ-002 Parameter N_IN, default 16: number of physical input pins.
REQ-003 Parameter N_OUT, default 16: number of physical output pins.
REQ-004 Parameter IN_BASE, default 0: bit-RAM address of input image bit 0.
REQ-005 Parameter OUT_BASE, default 16: bit-RAM address of output image bit 0.
REQ-006 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 scan_start  input  1  request one I/O scan; sampled only in IDLE.
REQ-009 scan_busy  output  1  high while a scan is in progress.
REQ-010 scan_done  output  1  one-cycle pulse at scan completion.
REQ-011 in_pins  input  N_IN  asynchronous external inputs.
REQ-012 out_pins  output  N_OUT  registered external outputs.
REQ-013 ram_rd_address  output  AWIDTH  to bit-RAM read port B address.
REQ-014 ram_rd_data  input  1  from bit-RAM read port B; valid 1 cycle after address.
REQ-015 ram_wr_address  output  AWIDTH  to bit-RAM write port C address.
REQ-016 ram_wr_data  output  1  to bit-RAM write port C data.
REQ-017 ram_wr_we  output  1  to bit-RAM write port C write enable.

Function
REQ-018 in_pins SHALL pass through a 2-flop synchronizer on every bit before use.
REQ-019 The FSM SHALL use states IDLE, IN_WR, OUT_RD, OUT_LAST, DONE.
REQ-020 IDLE: on scan_start=1, SHALL latch the synchronized inputs into a snapshot register, clear index counter, go IN_WR; scan_busy SHALL be high from the next cycle through DONE inclusive.
REQ-021 IN_WR: each cycle SHALL drive ram_wr_we=1, ram_wr_address=IN_BASE+i, ram_wr_data=snapshot[i], i=0..N_IN-1 ascending; after i=N_IN-1 go OUT_RD with counter cleared.
REQ-022 OUT_RD: each cycle SHALL drive ram_rd_address=OUT_BASE+j, j=0..N_OUT-1 ascending; ram_rd_data from the previous cycle SHALL be captured into shadow[j-1]; after j=N_OUT-1 go OUT_LAST.
REQ-023 OUT_LAST: SHALL capture ram_rd_data into shadow[N_OUT-1]; go DONE.
REQ-024 DONE: out_pins SHALL load shadow atomically (all bits same edge) and scan_done SHALL be 1 for this cycle only; go IDLE.
REQ-025 Total latency: scan_done SHALL assert exactly N_IN+N_OUT+2 cycles after the edge sampling scan_start.
REQ-026 ram_wr_we SHALL be 0 in every state except IN_WR.
REQ-027 ram_rd_address and ram_wr_address SHALL hold their last value outside their active states (no requirement on value).
REQ-028 scan_start asserted while scan_busy=1 SHALL be ignored and not queued.
REQ-029 scan_start held high continuously SHALL start a new scan on the IDLE cycle following each DONE (back-to-back scans, one idle cycle between).
REQ-030 out_pins SHALL change only in DONE or on reset; never mid-scan.
REQ-031 Address arithmetic SHALL be AWIDTH bits; elaboration SHALL fail if IN_BASE+N_IN or OUT_BASE+N_OUT exceeds 2^AWIDTH, or if the two ranges overlap.
REQ-032 N_IN=1 and N_OUT=1 SHALL be supported with identical state sequence.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, counter=0, snapshot=0, shadow=0, synchronizer=0, out_pins=0, scan_busy=0, scan_done=0, ram_wr_we=0.
REQ-034 rst mid-scan SHALL abort; no further RAM writes; out_pins SHALL read 0, not the partial shadow.
REQ-035 rst SHALL take priority over scan_start in the same cycle.

Verification
REQ-036 N_IN=N_OUT=16, in_pins=16'hA5C3 stable 3 cycles, pulse scan_start -> 16 writes at addr 0..15 with data bits of A5C3 LSB first, we=1 exactly 16 cycles.
REQ-037 RAM model with addr 16..31 preloaded 16'h3C0F, scan -> out_pins=16'h3C0F exactly on the scan_done cycle, 34 cycles after start; unchanged before.
REQ-038 scan_start pulsed at cycles 5 and 10 of an active scan -> single scan_done only; write/read sequence undisturbed.
REQ-039 rst asserted at cycle 20 of a scan -> ram_wr_we=0, scan_busy=0, out_pins=0 next cycle; no scan_done.
REQ-040 scan_start held high for 100 cycles -> scan_done pulses every 35 cycles, one IDLE cycle between scans.
REQ-041 N_IN=N_OUT=1, IN_BASE=0, OUT_BASE=1 -> scan_done 4 cycles after start, one write, one read.

Source files
------------

// File: rtl/bit_io_scan.sv
// rtl/bit_io_scan.sv - scans synchronized input pins into bit-RAM and refreshes output pins from it
module bit_io_scan #(
    parameter int AWIDTH   = 8,
    parameter int N_IN     = 16,
    parameter int N_OUT    = 16,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_done,
    input  logic [N_IN-1:0]   in_pins,
    output logic [N_OUT-1:0]  out_pins,
    output logic [AWIDTH-1:0] ram_rd_address,
    input  logic              ram_rd_data,
    output logic [AWIDTH-1:0] ram_wr_address,
    output logic              ram_wr_data,
    output logic              ram_wr_we
);

    localparam int NMAX = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CW   = $clog2(NMAX + 1);
    localparam longint ASPACE = longint'(1) << AWIDTH;

    if (longint'(IN_BASE) + longint'(N_IN) > ASPACE) begin : g_in_range_bad
        $error("bit_io_scan: input image exceeds bit-RAM address space");
    end
    if (longint'(OUT_BASE) + longint'(N_OUT) > ASPACE) begin : g_out_range_bad
        $error("bit_io_scan: output image exceeds bit-RAM address space");
    end
    if ((IN_BASE < OUT_BASE + N_OUT) && (OUT_BASE < IN_BASE + N_IN)) begin : g_overlap_bad
        $error("bit_io_scan: input and output images overlap");
    end

    typedef enum logic [2:0] {IDLE, IN_WR, OUT_RD, OUT_LAST, DONE} state_t;

    state_t            state;
    logic [N_IN-1:0]   sync1;
    logic [N_IN-1:0]   sync2;
    logic [N_IN-1:0]   snapshot;
    logic [N_OUT-1:0]  shadow;
    logic [N_OUT-1:0]  shadow_last;
    logic [CW-1:0]     cnt;

    // Final shadow image including the bit still arriving from the RAM this cycle.
    always_comb begin
        shadow_last            = shadow;
        shadow_last[N_OUT-1]   = ram_rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sync1          <= '0;
            sync2          <= '0;
            snapshot       <= '0;
            shadow         <= '0;
            cnt            <= '0;
            out_pins       <= '0;
            scan_busy      <= 1'b0;
            scan_done      <= 1'b0;
            ram_wr_we      <= 1'b0;
            ram_wr_data    <= 1'b0;
            ram_wr_address <= '0;
            ram_rd_address <= '0;
        end else begin
            sync1     <= in_pins;
            sync2     <= sync1;
            scan_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        snapshot       <= sync2;
                        cnt            <= '0;
                        scan_busy      <= 1'b1;
                        ram_wr_we      <= 1'b1;
                        ram_wr_address <= AWIDTH'(IN_BASE);
                        ram_wr_data    <= sync2[0];
                        state          <= IN_WR;
                    end
                end
                IN_WR: begin
                    if (cnt == CW'(N_IN - 1)) begin
                        ram_wr_we      <= 1'b0;
                        cnt            <= '0;
                        ram_rd_address <= AWIDTH'(OUT_BASE);
                        state          <= OUT_RD;
                    end else begin
                        cnt            <= cnt + 1'b1;
                        ram_wr_address <= ram_wr_address + 1'b1;
                        ram_wr_data    <= snapshot[cnt + 1'b1];
                    end
                end
                OUT_RD: begin
                    // Read data lags the address by one cycle.
                    if (cnt != '0) begin
                        shadow[cnt - 1'b1] <= ram_rd_data;
                    end
                    if (cnt == CW'(N_OUT - 1)) begin
                        state <= OUT_LAST;
                    end else begin
                        cnt            <= cnt + 1'b1;
                        ram_rd_address <= ram_rd_address + 1'b1;
                    end
                end
                OUT_LAST: begin
                    shadow    <= shadow_last;
                    out_pins  <= shadow_last;
                    scan_done <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    scan_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
